// File: rtl/ext_stream.sv
`timescale 1ns/1ps
// ext_stream: immediate extender whose results queue in a DEPTH-entry FIFO behind a valid/ready pair.
// Define EXT_ERR_EN to add the sticky illegal-mode flag on port err.
module ext_stream #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IMM_W-1:0]           imm,
  input  logic [2:0]                 EOp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef EXT_ERR_EN
  ,
  output logic                       err
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PAD_W = DATA_W - IMM_W;

  function automatic logic is_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [IMM_W-1:0] v, input logic [2:0] op);
    logic signed [DATA_W-1:0] s_ext;
    logic        [DATA_W-1:0] z_ext;
    logic        [DATA_W-1:0] r;
    s_ext = {{PAD_W{v[IMM_W-1]}}, v};
    z_ext = {{PAD_W{1'b0}}, v};
    case (op)
      3'b000:  r = s_ext;
      3'b001:  r = z_ext;
      3'b010:  r = {v, {PAD_W{1'b0}}};
      3'b011:  r = s_ext <<< SHIFT;
      3'b100:  r = z_ext << SHIFT;
      3'b101:  r = {{PAD_W{1'b1}}, v};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              in_fire, out_fire;
  logic [DATA_W-1:0] ext_p0;

  // Stage 0: handshake decode and combinational extension
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign ext_p0    = extend(imm, EOp);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (in_fire) begin
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      mem_d[wr_ptr_q] = ext_p0;
    end
    if (out_fire)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({in_fire, out_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage 1: FIFO state; storage is data-only and never reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef EXT_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (in_fire & is_illegal(EOp));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_ext_stream.sv
`timescale 1ns/1ps
// Directed bench for ext_stream: vector table for extension modes plus FIFO corner sequences.
module tb_ext_stream;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] imm;
  logic [2:0]  EOp;
  logic [31:0] out_data;
  logic [2:0]  count;
`ifdef EXT_ERR_EN
  logic        err;
`endif

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [7:0]  p_imm;
  logic [2:0]  p_EOp;
  logic [15:0] p_out_data;
  logic [2:0]  p_count;
`ifdef EXT_ERR_EN
  logic        p_err;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ext_stream u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .EOp(EOp), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count)
`ifdef EXT_ERR_EN
    , .err(err)
`endif
  );

  ext_stream #(.IMM_W(8), .DATA_W(16), .SHIFT(1), .DEPTH(4)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .imm(p_imm), .EOp(p_EOp), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_data(p_out_data), .count(p_count)
`ifdef EXT_ERR_EN
    , .err(p_err)
`endif
  );

  typedef struct {
    logic [15:0] imm;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] exp;
  } pvec_t;

  vec_t  vecs  [10];
  pvec_t pvecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{16'h8001, 3'b000, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 3'b001, 32'h00008001};
    vecs[2] = '{16'h8001, 3'b010, 32'h80010000};
    vecs[3] = '{16'h8001, 3'b011, 32'hFFFE0004};
    vecs[4] = '{16'h8001, 3'b100, 32'h00020004};
    vecs[5] = '{16'h0001, 3'b101, 32'hFFFF0001};
    vecs[6] = '{16'h7FFF, 3'b000, 32'h00007FFF};
    vecs[7] = '{16'hFFFF, 3'b011, 32'hFFFFFFFC};
    vecs[8] = '{16'h1234, 3'b110, 32'h00000000};
    vecs[9] = '{16'h1234, 3'b111, 32'h00000000};
    pvecs[0] = '{3'b000, 16'hFFC3};
    pvecs[1] = '{3'b010, 16'hC300};
    pvecs[2] = '{3'b011, 16'hFF86};
    pvecs[3] = '{3'b100, 16'h0186};

    reset_n = 1'b0;
    in_valid = 1'b0; imm = 'x; EOp = 'x; out_ready = 1'b1;
    p_in_valid = 1'b0; p_imm = '0; p_EOp = '0; p_out_ready = 1'b1;
    #12 reset_n = 1'b1;
    step();

    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
`ifdef EXT_ERR_EN
    check("rst_err", {31'b0, err}, 32'd0);
`endif

    // Extension modes, latency 1, drained immediately
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; imm = vecs[i].imm; EOp = vecs[i].op;
      step();
      in_valid = 1'b0; imm = 'x; EOp = 'x;
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_count", i), {29'b0, count}, 32'd1);
`ifdef EXT_ERR_EN
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, (vecs[i].op[2] & vecs[i].op[1])});
`endif
      step();
      check($sformatf("vec%0d_drained", i), {29'b0, count}, 32'd0);
    end

    // Backpressure: fill, hold off a 5th request, then drain in order
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; imm = 16'h0010 + 16'(k); EOp = 3'b001;
      step();
      check($sformatf("bp_fill%0d", k), {29'b0, count}, 32'(k + 1));
    end
    check("bp_full_ready", {31'b0, in_ready}, 32'd0);
    imm = 16'h0014;
    step();
    check("bp_held_count", {29'b0, count}, 32'd4);
    check("bp_hold_data", out_data, 32'h00000010);
    out_ready = 1'b1;
    step();
    check("bp_pop_count", {29'b0, count}, 32'd3);
    check("bp_pop_ready", {31'b0, in_ready}, 32'd1);
    check("bp_pop_data", out_data, 32'h00000011);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0; imm = 'x; EOp = 'x;
    check("bp_refill", {29'b0, count}, 32'd4);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_drain%0d_valid", j), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_drain%0d_data", j), out_data, 32'h00000011 + 32'(j));
      step();
    end
    check("bp_empty_count", {29'b0, count}, 32'd0);
    check("bp_empty_valid", {31'b0, out_valid}, 32'd0);

    // Simultaneous push/pop at count=2 across pointer wrap
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; imm = 16'h0020 + 16'(k); EOp = 3'b001;
      step();
    end
    check("sim_pre_count", {29'b0, count}, 32'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      imm = 16'h0022 + 16'(k);
      check($sformatf("sim%0d_data", k), out_data, 32'h00000020 + 32'(k));
      step();
      check($sformatf("sim%0d_count", k), {29'b0, count}, 32'd2);
    end
    in_valid = 1'b0; imm = 'x; EOp = 'x;
    check("sim_tail0", out_data, 32'h0000002A);
    step();
    check("sim_tail1", out_data, 32'h0000002B);
    step();
    check("sim_empty", {29'b0, count}, 32'd0);

`ifdef EXT_ERR_EN
    check("err_sticky", {31'b0, err}, 32'd1);
`endif

    // Asynchronous reset with three entries queued
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; imm = 16'h0030 + 16'(k); EOp = 3'b001;
      step();
    end
    in_valid = 1'b0; imm = 'x; EOp = 'x;
    check("mid_pre_count", {29'b0, count}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_count", {29'b0, count}, 32'd0);
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef EXT_ERR_EN
    check("mid_err", {31'b0, err}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; imm = 16'h8001; EOp = 3'b000;
    step();
    in_valid = 1'b0; imm = 'x; EOp = 'x;
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_data", out_data, 32'hFFFF8001);
    check("post_rst_count", {29'b0, count}, 32'd1);
    step();
    check("post_rst_drained", {29'b0, count}, 32'd0);

    // Narrow configuration: IMM_W=8, DATA_W=16, SHIFT=1
    check("p_ready", {31'b0, p_in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      p_in_valid = 1'b1; p_imm = 8'hC3; p_EOp = pvecs[i].op;
      step();
      p_in_valid = 1'b0;
      check($sformatf("p%0d_valid", i), {31'b0, p_out_valid}, 32'd1);
      check($sformatf("p%0d_data", i), {16'b0, p_out_data}, {16'b0, pvecs[i].exp});
      step();
      check($sformatf("p%0d_drained", i), {29'b0, p_count}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/ext_stream.md
Name: ext_stream

Overview:
- Parametrised, buffered successor to the immediate extender.
- Accepts immediates with an extension-mode tag over a valid/ready handshake.
- Computes the DATA_W-bit extended value and queues it in a DEPTH-entry result FIFO.
- Sits between the decode stage and consumers that may stall, e.g. a multi-cycle ALU or address unit.

Parameters:
- IMM_W, 16, immediate input width; must satisfy 2 <= IMM_W < DATA_W.
- DATA_W, 32, extended output width.
- SHIFT, 2, left shift amount for the shifted modes; must satisfy 0 <= SHIFT < DATA_W.
- DEPTH, 4, result FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input request valid
- in_ready  out  1  block can accept a request this cycle
- imm  in  IMM_W  immediate field
- EOp  in  3  extension mode
- out_valid  out  1  head result valid
- out_ready  in  1  consumer accepts the head result
- out_data  out  DATA_W  extended result at FIFO head
- count  out  clog2(DEPTH+1)  number of occupied FIFO entries
- err  out  1  illegal-mode flag; exists only when EXT_ERR_EN is defined

Behaviour:
- Modes. S = sign-extend imm to DATA_W. Z = zero-extend imm to DATA_W.
  - 000: S
  - 001: Z
  - 010: imm placed in the upper bits: imm << (DATA_W-IMM_W), low bits 0
  - 011: S << SHIFT, truncated to DATA_W
  - 100: Z << SHIFT, truncated to DATA_W
  - 101: all ones above imm, i.e. {ones, imm}
  - 110, 111: illegal; the result written is 0
- Extension is combinational on the input side. The result is written into the FIFO on in_fire = in_valid & in_ready.
- in_ready = (count != DEPTH). It is combinational from state only and never depends on out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr], taken directly from the storage register.
- out_fire = out_valid & out_ready.
- Latency: a request accepted at edge N into an empty FIFO is presented with out_valid=1 after edge N. Minimum latency is 1 cycle; there is no combinational in-to-out path.
- Pointers: wr_ptr and rd_ptr are clog2(DEPTH) bits. Each advances by 1 on its fire and wraps from DEPTH-1 to 0.
- count update per edge:
  - +1 on in_fire only
  - -1 on out_fire only
  - unchanged on both or neither
- Full (count=DEPTH): in_ready=0, so no write. A pop in that cycle frees a slot; in_ready returns to 1 in the following cycle.
- Empty (count=0): out_valid=0 and out_data holds the stale entry. The bench must not check out_data while out_valid=0.
- Simultaneous push and pop at 0 < count < DEPTH: both happen and count is unchanged.
- Hold rule: while out_valid=1 and out_ready=0, out_data stays stable.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, so in_ready=1 and out_valid=0. out_data reads mem[0]; memory contents are not reset.
- Reset mid-operation: reset asserts asynchronously and drops all queued results. No partial output is held over.
- Input values are ignored when in_valid=0. X on imm or EOp while in_valid=0 must not propagate into state.

Optional Feature:
- Macro: EXT_ERR_EN.
- Defined: port err exists.
  - err is sticky; it is set on the edge where in_fire occurs with EOp in {110, 111}.
  - err is cleared only by reset; its reset value is 0.
  - The illegal result (0) is still queued as normal.
- Undefined: no err port and no flag register. Illegal modes silently queue 0.

Test Plan:
- Defaults. Push imm=16'h8001, EOp=000 -> FFFF8001. Then EOp=001 -> 00008001, EOp=010 -> 80010000, EOp=011 -> FFFE0004, EOp=100 -> 00020004, EOp=101 with imm=16'h0001 -> FFFF0001. Each result has latency 1 and out_ready held 1.
- Backpressure. out_ready=0, push 5 requests -> count reaches 4 and in_ready=0 after the 4th. The 5th is held off until one pop; then all 5 drain in FIFO order with no loss or duplicate.
- Simultaneous. count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2 and outputs follow the input order. Covers pointer wrap past DEPTH-1.
- Reset mid-operation. Assert reset_n=0 asynchronously with count=3 -> out_valid=0, count=0, in_ready=1 immediately. After release, the first push yields the correct result.
- EXT_ERR_EN defined. Push EOp=110 -> a 00000000 result is queued and err=1 on that edge. err stays 1 after later legal pushes and clears only on reset.
- Parametrised. IMM_W=8, DATA_W=16, SHIFT=1, imm=8'hC3 -> EOp 000=FFC3, 010=C300, 011=FF86, 100=0186.
